// File: rtl/apb_completer_if.sv
// APB bus bundle between a requester and the apb_completer register file.
// The master modport is the requester side; slave is the completer side.
interface apb_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer.sv
// APB completer with a byte-strobed register file, programmable wait states,
// and pslverr on unaligned, out-of-range or protocol-violating transfers.
module apb_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic            pclk,
    input  logic            preset,
    apb_completer_if.slave  bus
);
    localparam int NLANES = DATA_WIDTH / 8;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [NLANES-1:0]       r_strb;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    logic                    w_in_err;
    logic                    w_lat_err;
    logic [IDX_W-1:0]        w_in_idx;
    logic [IDX_W-1:0]        w_lat_idx;
    logic [DATA_WIDTH-1:0]   w_in_rdata;
    logic [DATA_WIDTH-1:0]   w_lat_rdata;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_violation;

    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_WIDTH-1:2] >= WORD_W'(NUM_REGS));
    endfunction

    // Input-side decode is only needed for the zero-wait-state response,
    // which must be formed at the setup edge before anything is latched.
    assign w_in_err    = addr_err(bus.paddr);
    assign w_lat_err   = addr_err(r_addr);
    assign w_in_idx    = bus.paddr[IDX_W+1:2];
    assign w_lat_idx   = r_addr[IDX_W+1:2];
    assign w_in_rdata  = r_regs[w_in_idx];
    assign w_lat_rdata = r_regs[w_lat_idx];

    assign w_violation = !bus.psel || (bus.paddr != r_addr) || (bus.pwrite != r_write);

    always_comb begin
        w_merged = w_lat_rdata;
        for (int unsigned i = 0; i < NLANES; i++) begin
            if (r_strb[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.psel && !bus.penable) begin
                        r_addr  <= bus.paddr;
                        r_write <= bus.pwrite;
                        r_wdata <= bus.pwdata;
                        r_strb  <= bus.pstrb;
                        r_cnt   <= WS;
                        r_state <= S_ACCESS;
                        if (WAIT_STATES == 0) begin
                            r_pready  <= 1'b1;
                            r_pslverr <= w_in_err;
                            r_prdata  <= (!bus.pwrite && !w_in_err) ? w_in_rdata : '0;
                        end
                    end
                end

                S_ACCESS: begin
                    if (w_violation) begin
                        r_state   <= S_ERR;
                        r_pready  <= 1'b1;
                        r_pslverr <= 1'b1;
                        r_prdata  <= '0;
                    end else if (!r_pready) begin
                        if (r_cnt > 4'd1) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_cnt     <= '0;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_lat_err;
                            r_prdata  <= (!r_write && !w_lat_err) ? w_lat_rdata : '0;
                        end
                    end else if (bus.penable) begin
                        if (r_write && !w_lat_err) begin
                            r_regs[w_lat_idx] <= w_merged;
                        end
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                        r_state   <= S_IDLE;
                    end
                end

                S_ERR: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: one instance with one wait state and one
// with zero wait states, driven through a shared requester model.
module tb_apb_completer;
    logic        clk = 1'b0;
    logic        preset;
    logic        tgt0;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic        obs_pready;
    logic        obs_pslverr;
    logic [31:0] obs_prdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1();
    apb_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0();

    assign bus1.psel    = psel & ~tgt0;
    assign bus0.psel    = psel & tgt0;
    assign bus1.penable = penable;
    assign bus0.penable = penable;
    assign bus1.pwrite  = pwrite;
    assign bus0.pwrite  = pwrite;
    assign bus1.paddr   = paddr;
    assign bus0.paddr   = paddr;
    assign bus1.pwdata  = pwdata;
    assign bus0.pwdata  = pwdata;
    assign bus1.pstrb   = pstrb;
    assign bus0.pstrb   = pstrb;

    assign obs_pready  = tgt0 ? bus0.pready  : bus1.pready;
    assign obs_pslverr = tgt0 ? bus0.pslverr : bus1.pslverr;
    assign obs_prdata  = tgt0 ? bus0.prdata  : bus1.prdata;

    apb_completer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1)
    ) u_dut (
        .pclk(clk), .preset(preset), .bus(bus1.slave)
    );

    apb_completer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)
    ) u_dut0 (
        .pclk(clk), .preset(preset), .bus(bus0.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Full setup/access transfer; inputs change #1 after a rising edge.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int waits;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!obs_pready && waits < 16) begin
            waits++;
            @(posedge clk); #1;
        end
        check({tag, "_pready"}, 32'(obs_pready), 32'd1);
        check({tag, "_waits"}, 32'(waits), tgt0 ? 32'd0 : 32'd1);
        check({tag, "_pslverr"}, 32'(obs_pslverr), 32'(exp_err));
        check({tag, "_prdata"}, obs_prdata, exp_rdata);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check({tag, "_done_pready"}, 32'(obs_pready), 32'd0);
        check({tag, "_done_prdata"}, obs_prdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        preset = 1'b1; tgt0 = 1'b0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 32'(obs_pready), 32'd0);
        check("rst_pslverr", 32'(obs_pslverr), 32'd0);
        check("rst_prdata", obs_prdata, 32'd0);
        preset = 1'b0;

        xfer("t1_wr4", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer("t1_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        xfer("t2_wr8a", 1'b1, 32'h8, 32'h11223344, 4'hF, 32'h0, 1'b0);
        xfer("t2_wr8b", 1'b1, 32'h8, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0);
        xfer("t2_rd8", 1'b0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        xfer("t2_wr8z", 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        xfer("t2_rd8z", 1'b0, 32'h8, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        xfer("t3_rd3", 1'b0, 32'h3, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer("t3_wr6", 1'b1, 32'h6, 32'h12345678, 4'hF, 32'h0, 1'b1);
        xfer("t3_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // psel dropped during the access phase
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h4; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b1;
        @(posedge clk); #1;
        check("t4_err_pready", 32'(obs_pready), 32'd1);
        check("t4_err_pslverr", 32'(obs_pslverr), 32'd1);
        check("t4_err_prdata", obs_prdata, 32'd0);
        penable = 1'b0;
        @(posedge clk); #1;
        check("t4_after_pready", 32'(obs_pready), 32'd0);
        check("t4_after_pslverr", 32'(obs_pslverr), 32'd0);
        xfer("t4_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        xfer("t5_rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer("t5_wr40", 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b1);
        xfer("t5_rd0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer("t5_wr3c", 1'b1, 32'h3C, 32'h87654321, 4'hF, 32'h0, 1'b0);
        xfer("t5_rd3c", 1'b0, 32'h3C, 32'h0, 4'h0, 32'h87654321, 1'b0);

        tgt0 = 1'b1;
        xfer("z_wr4", 1'b1, 32'h4, 32'h55AA55AA, 4'hF, 32'h0, 1'b0);
        xfer("z_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);
        xfer("z_rd40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);
        tgt0 = 1'b0;

        // reset asserted during the wait state of a read
        xfer("t6_wrc", 1'b1, 32'hC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hC; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1; preset = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_pready", 32'(obs_pready), 32'd0);
        check("t6_rst_pslverr", 32'(obs_pslverr), 32'd0);
        check("t6_rst_prdata", obs_prdata, 32'd0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer("t6_rdc", 1'b0, 32'hC, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer("t6_rd4", 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
APB completer (peripheral) holding a small byte-strobed register file. It is the responder end of the APB interface that apb_bridge drives.
- Accepts read and write transfers, inserts a programmable number of wait states, then returns prdata/pready/pslverr.
- Flags unaligned addresses, out-of-range addresses and requester protocol violations with pslverr.

Parameters:
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
NUM_REGS, 16, number of 32-bit registers; word index = paddr[ADDR_WIDTH-1:2]
WAIT_STATES, 1, access cycles with pready low before completion (0..15)

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
psel  in  1  completer select
penable  in  1  access phase indicator
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes; ignored on reads
prdata  out  DATA_WIDTH  read data
pready  out  1  transfer completion
pslverr  out  1  error response, valid only with pready

Behaviour:
Interface: one clock (pclk); reset (preset) is synchronous and active-high.
- All outputs are registered.

Reset (preset=1 at an edge):
- state=IDLE, wait counter=0.
- prdata=0, pready=0, pslverr=0.
- All registers cleared to 0. This applies mid-transfer: any in-flight transfer is dropped with no write.

States: IDLE, ACCESS, ERR.

IDLE:
- psel=1 and penable=0 sampled: latch paddr, pwrite, pwdata, pstrb; cnt=WAIT_STATES; go to ACCESS.
- If WAIT_STATES==0, pready is set at this same edge, so it is high in the first access cycle.
- psel=1 with penable=1 in IDLE is ignored (stay IDLE, outputs 0).

ACCESS, at each edge:
- psel=0, or paddr/pwrite differs from the latched value: go to ERR. Set pready=1, pslverr=1, prdata=0. No register write.
- Else if pready=0 and cnt>1: cnt--.
- Else if pready=0 and cnt==1: cnt=0 and set pready=1, with pslverr and prdata as defined below.
- Else if pready=1 and psel&penable sampled: transfer completes.
  - Commit the write if there is no error.
  - pready=0, pslverr=0, prdata=0; go to IDLE.
- The net effect is exactly WAIT_STATES access cycles with pready low.

ERR:
- Response is held for one cycle, then pready=0, pslverr=0; go to IDLE regardless of the inputs.

Error rules, evaluated on the latched request:
- paddr[1:0]!=0 gives an error (unaligned).
- Word index >= NUM_REGS gives an error (out of range).
- On error: pslverr=1 with pready, prdata=0, and writes are suppressed.

Write commit:
- For each lane i with pstrb[i]=1, reg[idx][8i+7:8i] = pwdata[8i+7:8i]. Other lanes are unchanged.
- pstrb=0 is a legal no-op write (pslverr=0).

Read data:
- prdata = reg[idx] while pready=1 on a good read; 0 at all other times.
- Reads have no side effects.

Back-to-back transfers:
- A new setup phase is accepted in the cycle after completion (IDLE sampled at the next edge).
- Writes and reads to the same register on consecutive transfers see the updated value.

Test Plan:
1. Reset, write 0xDEADBEEF to 0x4 with pstrb=0xF, then read 0x4 (WAIT_STATES=1) -> exactly one access cycle with pready=0; prdata=0xDEADBEEF, pslverr=0; prdata=0 after completion.
2. Write 0x11223344 to 0x8 with pstrb=0xF, then 0xAABBCCDD with pstrb=0x5, then read 0x8 -> prdata=0x11BB33DD.
3. Read 0x3, then write 0x12345678 to 0x6, then read 0x4 -> read of 0x3 gives pready=1, pslverr=1, prdata=0; write to 0x6 gives pslverr=1; read of 0x4 still returns its prior value.
4. Setup at 0x4, then drop psel while penable=1 in the access phase -> next cycle pready=1, pslverr=1; following cycle pready=0; reg1 unchanged.
5. Read and write 0x40 with NUM_REGS=16 -> pslverr=1 on both; no register modified. Rebuild with WAIT_STATES=0: read 0x4 -> pready=1 in the first access cycle.
6. Write 0xCAFEF00D to 0xC, start a read of 0xC, assert preset during the wait state -> outputs 0 the next cycle; a subsequent read of 0xC returns 0x00000000, pslverr=0.
